// File: rtl/pulse_transmitter_reload_timer_pkg.sv
// Shared types and helpers for the reload timer: FSM states, prescaler port width, period arithmetic.
// No logic, no latency; nothing here applies backpressure.
package pulse_transmitter_reload_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int prescaler_width(input int max_shift);
        return $clog2(max_shift + 1);
    endfunction

    // ((d+1) << p) - 1; the result fits in (duration width + max shift) bits, callers truncate to that
    function automatic logic [63:0] period_m1(input logic [31:0] duration, input logic [31:0] shift);
        return ((64'(duration) + 64'd1) << shift) - 64'd1;
    endfunction

endpackage

// File: rtl/pulse_transmitter_reload_slot.sv
// One-deep shadow slot for the next segment; written one edge after the handshake, readable the cycle after.
// Ready only when empty and not being cleared; clear beats push, push and pop never coincide.
module pulse_transmitter_reload_slot #(
    parameter int PSW = 4,
    parameter int TW  = 8
) (
    input  logic           clk,
    input  logic           sys_rst_n,
    input  logic           clear,
    input  logic           pop,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [PSW-1:0] load_prescaler,
    input  logic [TW-1:0]  load_duration,
    input  logic           load_last,
    output logic           slot_valid,
    output logic [PSW-1:0] slot_prescaler,
    output logic [TW-1:0]  slot_duration,
    output logic           slot_last
);

    assign load_ready = !slot_valid && !clear;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            slot_valid     <= 1'b0;
            slot_prescaler <= '0;
            slot_duration  <= '0;
            slot_last      <= 1'b0;
        end else if (clear) begin
            slot_valid <= 1'b0;
        end else if (load_valid && load_ready) begin
            slot_valid     <= 1'b1;
            slot_prescaler <= load_prescaler;
            slot_duration  <= load_duration;
            slot_last      <= load_last;
        end else if (pop) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_transmitter_reload_timer.sv
// Countdown timer with a shadow reload slot; pulse_out one cycle after the expiry edge, P edges after transfer.
// Loads backpressured while the slot is full or stop is high. Optional count_out via PULSE_TRANSMITTER_TIMER_COUNT_OUT_EN.
module pulse_transmitter_reload_timer
    import pulse_transmitter_reload_timer_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 15,
    parameter int TIMER_WIDTH     = 8
) (
    input  logic                                         clk,
    input  logic                                         sys_rst_n,
    input  logic                                         en,
    input  logic                                         stop,
    input  logic                                         repeat_mode,
    input  logic                                         load_valid,
    output logic                                         load_ready,
    input  logic [prescaler_width(PRESCALER_WIDTH)-1:0]  load_prescaler,
    input  logic [TIMER_WIDTH-1:0]                       load_duration,
    input  logic                                         load_last,
    output logic                                         pulse_out,
    output logic                                         done,
    output logic                                         underrun,
    output logic                                         busy
`ifdef PULSE_TRANSMITTER_TIMER_COUNT_OUT_EN
    ,
    output logic [PRESCALER_WIDTH+TIMER_WIDTH-1:0]       count_out
`endif
);

    localparam int COUNTER_WIDTH = PRESCALER_WIDTH + TIMER_WIDTH;
    localparam int PSW           = prescaler_width(PRESCALER_WIDTH);

    state_t                   state, state_nxt;
    logic [COUNTER_WIDTH-1:0] counter, counter_nxt;
    logic [PSW-1:0]           act_prescaler, act_prescaler_nxt;
    logic [TIMER_WIDTH-1:0]   act_duration, act_duration_nxt;
    logic                     act_last, act_last_nxt;
    logic                     pulse_nxt, done_nxt, underrun_nxt;
    logic                     pop;

    logic                     slot_valid;
    logic [PSW-1:0]           slot_prescaler;
    logic [TIMER_WIDTH-1:0]   slot_duration;
    logic                     slot_last;

    pulse_transmitter_reload_slot #(
        .PSW (PSW),
        .TW  (TIMER_WIDTH)
    ) u_slot (
        .clk            (clk),
        .sys_rst_n      (sys_rst_n),
        .clear          (stop),
        .pop            (pop),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_prescaler (load_prescaler),
        .load_duration  (load_duration),
        .load_last      (load_last),
        .slot_valid     (slot_valid),
        .slot_prescaler (slot_prescaler),
        .slot_duration  (slot_duration),
        .slot_last      (slot_last)
    );

    always_comb begin
        state_nxt         = state;
        counter_nxt       = counter;
        act_prescaler_nxt = act_prescaler;
        act_duration_nxt  = act_duration;
        act_last_nxt      = act_last;
        pulse_nxt         = 1'b0;
        done_nxt          = 1'b0;
        underrun_nxt      = 1'b0;
        pop               = 1'b0;
        if (stop) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && slot_valid) begin
                        state_nxt         = RUN;
                        pop               = 1'b1;
                        act_prescaler_nxt = slot_prescaler;
                        act_duration_nxt  = slot_duration;
                        act_last_nxt      = slot_last;
                        counter_nxt       = COUNTER_WIDTH'(period_m1(32'(slot_duration), 32'(slot_prescaler)));
                    end
                end
                RUN: begin
                    if (en) begin
                        if (counter != '0) begin
                            counter_nxt = counter - COUNTER_WIDTH'(1);
                        end else begin
                            // expiry: queued successor first, then repeat, then end of sequence
                            pulse_nxt = 1'b1;
                            if (slot_valid) begin
                                pop               = 1'b1;
                                act_prescaler_nxt = slot_prescaler;
                                act_duration_nxt  = slot_duration;
                                act_last_nxt      = slot_last;
                                counter_nxt       = COUNTER_WIDTH'(period_m1(32'(slot_duration), 32'(slot_prescaler)));
                            end else if (repeat_mode) begin
                                counter_nxt = COUNTER_WIDTH'(period_m1(32'(act_duration), 32'(act_prescaler)));
                            end else begin
                                state_nxt    = IDLE;
                                done_nxt     = act_last;
                                underrun_nxt = !act_last;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            act_prescaler <= '0;
            act_duration  <= '0;
            act_last      <= 1'b0;
            pulse_out     <= 1'b0;
            done          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= state_nxt;
            counter       <= counter_nxt;
            act_prescaler <= act_prescaler_nxt;
            act_duration  <= act_duration_nxt;
            act_last      <= act_last_nxt;
            pulse_out     <= pulse_nxt;
            done          <= done_nxt;
            underrun      <= underrun_nxt;
        end
    end

    assign busy = (state == RUN);

`ifdef PULSE_TRANSMITTER_TIMER_COUNT_OUT_EN
    assign count_out = counter;
`endif

endmodule
